// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants for the synchronous FIFO family: default geometry, default
// almost-empty / almost-full placement, and the read-mode encoding used to
// select registered-read or first-word-fall-through behaviour.
// No ports (package).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AE_LEVEL   = 2;
  // almost_full sits this many entries below completely full by default.
  localparam int FIFO_AF_MARGIN  = 2;

  // Read-mode encoding, shared with the other FIFO variants.
  typedef enum logic {
    FWFT_REGISTERED = 1'b0,  // data_out loads on an accepted read
    FWFT_SHOWAHEAD  = 1'b1   // data_out always shows the head word
  } fwft_mode_e;

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// DEPTH x DATA_WIDTH register array used as FIFO storage.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (asynchronous read)
//   rdata  out  word stored at raddr
// -----------------------------------------------------------------------------
module fifo_mem_dp
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage deliberately has no reset; validity is tracked by the
  // pointers, so clearing the array would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem_dp

// File: rtl/synchronous_fifo_3.sv
// -----------------------------------------------------------------------------
// synchronous_fifo_3
// Single-clock elastic buffer with occupancy count, threshold flags, sticky
// overflow/underflow flags, synchronous flush and selectable read mode.
// Ports:
//   clk           in   clock, all state on rising edge
//   rst           in   asynchronous active-low reset
//   clr           in   synchronous flush (beats w_en / r_en)
//   w_en, r_en    in   write / read requests
//   data_in       in   write data
//   data_out      out  read data (registered or show-ahead, see FWFT)
//   full, empty   out  occupancy flags
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  current occupancy, 0..DEPTH
//   overflow      out  sticky: a write was attempted while full
//   underflow     out  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module synchronous_fifo_3
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int FWFT       = int'(FWFT_REGISTERED),
  parameter int AF_LEVEL   = DEPTH - FIFO_AF_MARGIN,
  parameter int AE_LEVEL   = FIFO_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam bit SHOW_AHEAD = (FWFT == int'(FWFT_SHOWAHEAD));

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] head_word;

  // Flags come straight from the registered count, so acceptance below is
  // always judged against the occupancy that existed before the edge.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = w_en && !full;
  assign rd_accept = r_en && !empty;

  always_comb begin
    // NOTE: every comb output gets its hold value first, so no branch can
    // leave one unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_accept) rd_ptr_d = rd_ptr_q + ONE_C;

      // A simultaneous accepted read and write leave the occupancy unchanged.
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase

      overflow_d  = overflow_q  || (w_en && full);
      underflow_d = underflow_q || (r_en && empty);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept && !clr),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (head_word)
  );

  if (SHOW_AHEAD) begin : g_show_ahead
    // The head word is visible whenever something is stored; the output is
    // zeroed when empty so stale memory never leaks out.
    assign data_out = empty ? '0 : head_word;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (clr)            dout_d = '0;
      else if (rd_accept) dout_d = head_word;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout_q <= '0;
      else      dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule : synchronous_fifo_3

// File: tb/tb_synchronous_fifo_3.sv
// -----------------------------------------------------------------------------
// tb_synchronous_fifo_3
// Two instances share one stimulus stream: u_dut0 in registered-read mode and
// u_dut1 in first-word-fall-through mode. A queue-based reference model tracks
// contents, sticky errors and the registered output word.
// -----------------------------------------------------------------------------
module tb_synchronous_fifo_3;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] d0_data, d1_data;
  logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [AW:0]   d0_count, d1_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [DW-1:0] m_dout0 = '0;

  always #5 clk = ~clk;

  synchronous_fifo_3 #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(d0_data), .full(d0_full), .empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_unf)
  );

  synchronous_fifo_3 #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(d1_data), .full(d1_full), .empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    int sz = mq.size();
    if (c) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_dout0 = '0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
      if (r && sz > 0)      m_dout0 = mq.pop_front();
      if (w && sz < DEPTH)  mq.push_back(d);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_dout0 = '0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, then sample 1 ns later.
  task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    w_en = w; r_en = r; clr = c; data_in = d;
    @(posedge clk);
    model_update(w, r, c, d);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int            sz   = mq.size();
    logic [DW-1:0] head = (sz > 0) ? mq[0] : '0;
    check({tag, ".count0"}, 32'(d0_count), 32'(sz));
    check({tag, ".count1"}, 32'(d1_count), 32'(sz));
    check({tag, ".full"},   32'({d0_full,  d1_full}),  32'({2{sz == DEPTH}}));
    check({tag, ".empty"},  32'({d0_empty, d1_empty}), 32'({2{sz == 0}}));
    check({tag, ".af"},     32'({d0_af, d1_af}),       32'({2{sz >= AF}}));
    check({tag, ".ae"},     32'({d0_ae, d1_ae}),       32'({2{sz <= AE}}));
    check({tag, ".ovf"},    32'({d0_ovf, d1_ovf}),     32'({2{m_ovf}}));
    check({tag, ".unf"},    32'({d0_unf, d1_unf}),     32'({2{m_unf}}));
    check({tag, ".dout0"},  32'(d0_data), 32'(m_dout0));
    check({tag, ".dout1"},  32'(d1_data), 32'(head));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".count"}, 32'({d0_count, d1_count}), 32'(0));
    check({tag, ".empty"}, 32'({d0_empty, d1_empty, d0_ae, d1_ae}), 32'(4'hF));
    check({tag, ".full"},  32'({d0_full, d1_full, d0_af, d1_af}), 32'(0));
    check({tag, ".err"},   32'({d0_ovf, d1_ovf, d0_unf, d1_unf}), 32'(0));
    check({tag, ".dout"},  32'({d0_data, d1_data}), 32'(0));
  endtask

  typedef struct {
    bit            w, r, c;
    logic [DW-1:0] d;
    int            exp_count;
    bit            exp_empty;
    bit            exp_unf;
    logic [DW-1:0] exp_dout0;
    logic [DW-1:0] exp_dout1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] exp_words[10];

    // Short basic sequence from reset, expectations written out by hand.
    vecs[0] = '{1, 0, 0, 8'h11, 1, 0, 0, 8'h00, 8'h11};
    vecs[1] = '{1, 0, 0, 8'h22, 2, 0, 0, 8'h00, 8'h11};
    vecs[2] = '{0, 1, 0, 8'h00, 1, 0, 0, 8'h11, 8'h22};
    vecs[3] = '{1, 1, 0, 8'h33, 1, 0, 0, 8'h22, 8'h33};
    vecs[4] = '{0, 1, 0, 8'h00, 0, 1, 0, 8'h33, 8'h00};
    vecs[5] = '{0, 1, 0, 8'h00, 0, 1, 1, 8'h33, 8'h00};
    vecs[6] = '{1, 1, 0, 8'h44, 1, 0, 1, 8'h33, 8'h44};
    vecs[7] = '{0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 8'h00};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d);
      check($sformatf("vec%0d.count", i), 32'(d0_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.empty", i), 32'(d1_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.unf", i),   32'(d0_unf),   32'(vecs[i].exp_unf));
      check($sformatf("vec%0d.dout0", i), 32'(d0_data),  32'(vecs[i].exp_dout0));
      check($sformatf("vec%0d.dout1", i), 32'(d1_data),  32'(vecs[i].exp_dout1));
    end

    // Fill to full, overflow, then drain in order.
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1, 0, 0, DW'(k));
      check($sformatf("fill%0d.af", k),   32'(d0_af),   32'(k >= 14));
      check($sformatf("fill%0d.full", k), 32'(d0_full), 32'(k == 16));
      check_model($sformatf("fill%0d", k));
    end
    cycle(1, 0, 0, 8'hAA);
    check("ovf.flag",  32'(d0_ovf),   32'(1));
    check("ovf.count", 32'(d0_count), 32'(16));
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0, 8'h00);
      check($sformatf("drain%0d.dout0", i), 32'(d0_data), 32'(i + 1));
      check_model($sformatf("drain%0d", i));
    end
    check("drain.empty", 32'(d0_empty), 32'(1));

    // Simultaneous read/write at count 5.
    cycle(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, DW'(8'hB0 + i));
    for (int j = 0; j < 4; j++) begin
      cycle(1, 1, 0, DW'(8'hC0 + j));
      check($sformatf("simul%0d.count", j), 32'(d0_count), 32'(5));
      check($sformatf("simul%0d.dout0", j), 32'(d0_data),  32'(8'hB0 + j));
    end
    cycle(0, 1, 0, 8'h00);
    check("simul.tail0", 32'(d0_data), 32'(8'hB4));
    for (int j = 0; j < 4; j++) begin
      cycle(0, 1, 0, 8'h00);
      check($sformatf("simul.tail%0d", j + 1), 32'(d0_data), 32'(8'hC0 + j));
    end
    cycle(1, 1, 0, 8'h77);
    check("both_empty.count", 32'(d0_count), 32'(1));
    check("both_empty.unf",   32'(d0_unf),   32'(1));
    check("both_empty.dout1", 32'(d1_data),  32'(8'h77));

    // Wrap-around: three rounds of 10 writes and 10 reads.
    cycle(0, 0, 1, 8'h00);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 10; i++) begin
        exp_words[i] = DW'($urandom);
        cycle(1, 0, 0, exp_words[i]);
      end
      for (int i = 0; i < 10; i++) begin
        check($sformatf("wrap%0d.head%0d", rnd, i), 32'(d1_data), 32'(exp_words[i]));
        cycle(0, 1, 0, 8'h00);
        check($sformatf("wrap%0d.dout%0d", rnd, i), 32'(d0_data), 32'(exp_words[i]));
      end
      check($sformatf("wrap%0d.empty", rnd), 32'({d0_empty, d1_empty}), 32'(2'b11));
    end

    // Show-ahead: word appears after the write edge without any read.
    cycle(0, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h3C);
    check("fwft.dout",  32'(d1_data),  32'(8'h3C));
    check("fwft.empty", 32'(d1_empty), 32'(0));
    cycle(0, 0, 0, 8'h00);
    check("fwft.hold",  32'(d1_data),  32'(8'h3C));
    cycle(0, 1, 0, 8'h00);
    check("fwft.rd_dout",  32'(d1_data),  32'(0));
    check("fwft.rd_empty", 32'(d1_empty), 32'(1));

    // Flush at count 7 with overflow set; the concurrent write is dropped.
    cycle(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 0, 0, DW'(i));
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 8'h00);
    check("flush.pre_count", 32'(d0_count), 32'(7));
    check("flush.pre_ovf",   32'(d0_ovf),   32'(1));
    cycle(1, 0, 1, 8'h99);
    check("flush.count", 32'({d0_count, d1_count}), 32'(0));
    check("flush.empty", 32'({d0_empty, d1_empty}), 32'(2'b11));
    check("flush.ovf",   32'({d0_ovf, d1_ovf}),     32'(0));
    check("flush.dout0", 32'(d0_data), 32'(0));
    cycle(0, 0, 0, 8'h00);
    check("flush.after", 32'(d0_count), 32'(0));

    // Asynchronous reset with count 9 and a non-zero registered output.
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, DW'(8'h60 + i));
    cycle(0, 1, 0, 8'h00);
    check("midrst.pre_count", 32'(d0_count), 32'(9));
    check("midrst.pre_dout0", 32'(d0_data),  32'(8'h60));
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 0, 0, 8'h55);
    check("postrst.count", 32'(d0_count), 32'(1));
    check("postrst.dout1", 32'(d1_data),  32'(8'h55));
    check_model("postrst");

    // Randomised traffic with alternating write-heavy / read-heavy phases.
    for (int n = 0; n < 1500; n++) begin
      bit            w, r, c;
      logic [DW-1:0] d;
      int            bias = ((n / 120) % 2 == 0) ? 80 : 30;
      w = ($urandom_range(99) < bias);
      r = ($urandom_range(99) < (110 - bias));
      c = ($urandom_range(199) == 0);
      d = DW'($urandom);
      cycle(w, r, c, d);
      check_model($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_synchronous_fifo_3
